n64_button_event_queue: RTL and testbench
=========================================

Name: n64_button_event_queue

Overview:
Downstream consumer of the 32-bit controller snapshot that the N64 serial interface updates atomically about every 1 ms. It diffs each new snapshot against the last committed one and turns every button edge and every joystick zone change into an 8-bit event. Events go into a first-word-fall-through FIFO that the host logic (CPU bus glue or game FSM) drains at its own pace.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..256.
DEADZONE, 8'd16, joystick magnitude that must be exceeded before an axis counts as deflected.
BUTTON_MASK, 16'hFF3F, per-button enable, index i maps to button_data[16+i]; default excludes the reserved bit and the L+R+Start reset bit.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  when 0, no new snapshots are captured; a scan already in progress completes
button_data  in  32  snapshot: [31:16] buttons, [15:8] stick X (signed), [7:0] stick Y (signed)
evt_pop  in  1  consume the head event this cycle
clear_overflow  in  1  clears the overflow flag
evt_data  out  EVT_W  head event; EVT_W=8 (24 with the optional feature)
evt_valid  out  1  FIFO not empty
evt_count  out  $clog2(DEPTH)+1  number of entries held
overflow  out  1  sticky: at least one event was dropped

Behaviour:
- Reset values: all outputs 0, FIFO empty, prev_buttons=0, prev_zone=0, FSM in IDLE.
- Event format: [7:6] type (00 release, 01 press, 10 stick), [5:0] payload. For press/release the payload is the button index 0..15. For stick the payload is {2'b00, up, down, left, right}.
- Zone logic: right = X > DEADZONE, left = X < -DEADZONE, up = Y > DEADZONE, down = Y < -DEADZONE. Comparisons are signed, 9-bit sign-extended, so X = -128 does not overflow.
- FSM states:
  - IDLE. If enable and (button_data[31:16]&BUTTON_MASK != prev_buttons, or zone(button_data) != prev_zone), latch cur = button_data, then go to SCAN with idx=0.
  - SCAN. One button index per cycle, idx 0..15. If cur bit differs from prev_buttons bit and the mask bit is set, push an event: press if cur=1, else release. After idx=15 go to STICK.
  - STICK. If zone(cur) != prev_zone, push a stick event. Commit prev_buttons and prev_zone from cur, then return to IDLE.
  - A full scan takes 18 cycles, which is far shorter than the 1 ms update period.
- Snapshots changing during SCAN/STICK are ignored. The next IDLE cycle compares the live input against the committed state, so no edge is lost; at most an intermediate state is skipped.
- Push ordering: events are pushed in ascending index order, with the stick event last.
- FIFO behaviour:
  - Push when full: the event is dropped, overflow is set, and the scan continues.
  - Push and pop in the same cycle while full: both succeed, count is unchanged.
  - Pop when empty: ignored, evt_data holds its last value, count stays 0.
  - evt_data is valid in the same cycle evt_valid rises, with one cycle of push-to-visible latency.
  - Pointers wrap modulo DEPTH.
- overflow clears on clear_overflow. If clear_overflow and a drop happen in the same cycle, set wins.
- Reset mid-scan: the FIFO is emptied and committed state is zeroed. The first snapshot after reset therefore reports every pressed button as a press event.

Optional Feature:
N64_EVT_TIMESTAMP_EN:
- When defined, a free-running 16-bit counter increments every 100000 clk cycles (1 ms ticks) and wraps at 0xFFFF.
- Each pushed event carries {timestamp[15:0], event[7:0]}, so EVT_W=24; the timestamp is sampled when the snapshot is latched in IDLE.
- When undefined, EVT_W=8 and the counter is not built.

Test Plan:
- From reset, button_data=32'h8000_0000 (A) → one event 8'h4F (press, idx 15); evt_count=1; no stick event.
- A held, then button_data=32'h2000_0000 (A released, Z pressed) → queue 8'h4D then 8'h0F.
- Stick X=8'd40, Y=0 → 8'h81; then X=8'hD8 (-40), Y=8'd40 → 8'h8A; X=8'd16 → no event (at deadzone), zone cleared → 8'h80.
- DEPTH=4, no pops, four snapshots each toggling 2 buttons → count=4, overflow=1; clear_overflow → overflow=0, queued data intact.
- Pop and push in the same cycle at full → count stays 4, order preserved; pop on empty → no change.
- Assert rst_n low at SCAN idx=7 → all outputs 0 immediately; after release, the held button is re-reported as a press.

Source files
------------

// File: rtl/n64_button_event_queue.sv
// Diffs each N64 controller snapshot against the last committed one and queues button/stick events in a FWFT FIFO.
// Optional macro N64_EVT_TIMESTAMP_EN widens events to {timestamp[15:0], event[7:0]}.
module n64_button_event_queue #(
    parameter int unsigned  DEPTH       = 16,
    parameter logic [7:0]   DEADZONE    = 8'd16,
    parameter logic [15:0]  BUTTON_MASK = 16'hFF3F,
`ifdef N64_EVT_TIMESTAMP_EN
    localparam int unsigned EVT_W       = 24,
`else
    localparam int unsigned EVT_W       = 8,
`endif
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [31:0]      button_data,
    input  logic             evt_pop,
    input  logic             clear_overflow,
    output logic [EVT_W-1:0] evt_data,
    output logic             evt_valid,
    output logic [AW:0]      evt_count,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, SCAN, STICK} state_e;

    // Zone bits are {up, down, left, right}; sign-extending to 9 bits keeps -128 and -DEADZONE exact.
    function automatic logic [3:0] zoneOf(input logic [15:0] xy);
        logic signed [8:0] x, y, dz;
        x  = {xy[15], xy[15:8]};
        y  = {xy[7], xy[7:0]};
        dz = {1'b0, DEADZONE};
        return {y > dz, y < -dz, x < -dz, x > dz};
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] cur_q, cur_d;
    logic [15:0] prev_buttons_q, prev_buttons_d;
    logic [3:0]  prev_zone_q, prev_zone_d;

    logic [15:0] liveButtons, curButtons;
    logic [3:0]  liveZone, curZone;
    logic        start;
    logic        pushValid;
    logic [7:0]  pushEvt;

    assign liveButtons = button_data[31:16] & BUTTON_MASK;
    assign curButtons  = cur_q[31:16] & BUTTON_MASK;
    assign liveZone    = zoneOf(button_data[15:0]);
    assign curZone     = zoneOf(cur_q[15:0]);
    assign start       = (state_q == IDLE) && enable &&
                         ((liveButtons != prev_buttons_q) || (liveZone != prev_zone_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            cur_q          <= '0;
            prev_buttons_q <= '0;
            prev_zone_q    <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cur_q          <= cur_d;
            prev_buttons_q <= prev_buttons_d;
            prev_zone_q    <= prev_zone_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cur_d          = cur_q;
        prev_buttons_d = prev_buttons_q;
        prev_zone_d    = prev_zone_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = button_data;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) state_d = STICK;
            end
            STICK: begin
                prev_buttons_d = curButtons;
                prev_zone_d    = curZone;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Committed buttons are stored pre-masked, so a plain bit compare already honours the mask.
    always_comb begin
        pushValid = 1'b0;
        pushEvt   = '0;
        case (state_q)
            SCAN: begin
                if (curButtons[idx_q] != prev_buttons_q[idx_q]) begin
                    pushValid = 1'b1;
                    pushEvt   = {1'b0, curButtons[idx_q], 2'b00, idx_q};
                end
            end
            STICK: begin
                if (curZone != prev_zone_q) begin
                    pushValid = 1'b1;
                    pushEvt   = {4'b1000, curZone};
                end
            end
            default: ;
        endcase
    end

    logic [EVT_W-1:0] pushData;
`ifdef N64_EVT_TIMESTAMP_EN
    logic [16:0] prescale_q;
    logic [15:0] ticks_q, snap_ts_q;

    // One tick per 100000 clocks (1 ms); the snapshot time is frozen when the scan starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= '0;
            ticks_q    <= '0;
            snap_ts_q  <= '0;
        end else begin
            if (prescale_q == 17'd99999) begin
                prescale_q <= '0;
                ticks_q    <= ticks_q + 16'd1;
            end else begin
                prescale_q <= prescale_q + 17'd1;
            end
            if (start) snap_ts_q <= ticks_q;
        end
    end
    assign pushData = {snap_ts_q, pushEvt};
`else
    assign pushData = pushEvt;
`endif

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             full, popEn, pushEn, drop;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign popEn  = evt_pop && (count_q != '0);
    assign pushEn = pushValid && (!full || popEn);
    assign drop   = pushValid && full && !popEn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pushEn) begin
                mem_q[wr_ptr_q] <= pushData;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (popEn) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (pushEn && !popEn)      count_q <= count_q + (AW+1)'(1);
            else if (!pushEn && popEn) count_q <= count_q - (AW+1)'(1);
            if (drop)                 overflow_q <= 1'b1;
            else if (clear_overflow)  overflow_q <= 1'b0;
        end
    end

    assign evt_data  = mem_q[rd_ptr_q];
    assign evt_valid = (count_q != '0);
    assign evt_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_n64_button_event_queue.sv
// Directed self-checking bench for n64_button_event_queue, built with DEPTH=4 so overflow is easy to reach.
module tb_n64_button_event_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] button_data = '0;
    logic        evt_pop = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [7:0]  evt_data;
    logic        evt_valid;
    logic [2:0]  evt_count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    n64_button_event_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .button_data(button_data),
        .evt_pop(evt_pop), .clear_overflow(clear_overflow), .evt_data(evt_data),
        .evt_valid(evt_valid), .evt_count(evt_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Drive a snapshot on a falling edge and let a full scan (18 cycles) finish.
    task automatic applyStimulus(input logic [31:0] bd, input int cycles);
        button_data = bd;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic popOne();
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (evt_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", evt_count); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", evt_valid); end
        checks++; if (evt_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", evt_data); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_press();
        applyStimulus(32'h8000_0000, 20);
        checks++; if (evt_count !== 3'd1) begin failures++; $display("[TB] FAIL press_count got=%0d exp=1", evt_count); end
        checks++; if (evt_valid !== 1'b1) begin failures++; $display("[TB] FAIL press_valid got=%b exp=1", evt_valid); end
        checks++; if (evt_data !== 8'h4F) begin failures++; $display("[TB] FAIL press_data got=%h exp=4f", evt_data); end
        popOne();
        checks++; if (evt_count !== 3'd0) begin failures++; $display("[TB] FAIL press_popped_count got=%0d exp=0", evt_count); end
    endtask

    task automatic test_swap();
        applyStimulus(32'h2000_0000, 20);
        checks++; if (evt_count !== 3'd2) begin failures++; $display("[TB] FAIL swap_count got=%0d exp=2", evt_count); end
        checks++; if (evt_data !== 8'h4D) begin failures++; $display("[TB] FAIL swap_first got=%h exp=4d", evt_data); end
        popOne();
        checks++; if (evt_data !== 8'h0F) begin failures++; $display("[TB] FAIL swap_second got=%h exp=0f", evt_data); end
        popOne();
    endtask

    task automatic test_stick();
        logic [31:0] snaps [7];
        logic [7:0]  expEvt [7];
        logic        expAny [7];
        snaps  = '{32'h2000_2800, 32'h2000_D828, 32'h2000_1000, 32'h2000_1010, 32'h2000_8000, 32'h2000_1100, 32'h2000_0000};
        expEvt = '{8'h81, 8'h8A, 8'h80, 8'h00, 8'h82, 8'h81, 8'h80};
        expAny = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(snaps[i], 20);
            if (expAny[i]) begin
                checks++; if (evt_count !== 3'd1) begin failures++; $display("[TB] FAIL stick_count[%0d] got=%0d exp=1", i, evt_count); end
                checks++; if (evt_data !== expEvt[i]) begin failures++; $display("[TB] FAIL stick_data[%0d] got=%h exp=%h", i, evt_data, expEvt[i]); end
                popOne();
            end else begin
                checks++; if (evt_count !== 3'd0) begin failures++; $display("[TB] FAIL stick_deadzone[%0d] got=%0d exp=0", i, evt_count); end
            end
        end
    endtask

    task automatic test_mask();
        applyStimulus(32'h2040_0000, 20);
        checks++; if (evt_count !== 3'd0) begin failures++; $display("[TB] FAIL mask_count got=%0d exp=0", evt_count); end
        applyStimulus(32'h2000_0000, 20);
    endtask

    task automatic test_enable();
        enable = 1'b0;
        applyStimulus(32'h0000_0000, 20);
        checks++; if (evt_count !== 3'd0) begin failures++; $display("[TB] FAIL enable_off_count got=%0d exp=0", evt_count); end
        enable = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (evt_count !== 3'd1) begin failures++; $display("[TB] FAIL enable_on_count got=%0d exp=1", evt_count); end
        checks++; if (evt_data !== 8'h0D) begin failures++; $display("[TB] FAIL enable_on_data got=%h exp=0d", evt_data); end
        popOne();
    endtask

    task automatic test_overflow();
        applyStimulus(32'h0003_0000, 20);
        applyStimulus(32'h0000_0000, 20);
        applyStimulus(32'h0003_0000, 20);
        applyStimulus(32'h0000_0000, 20);
        checks++; if (evt_count !== 3'd4) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=4", evt_count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_cleared got=%b exp=0", overflow); end
        checks++; if (evt_count !== 3'd4) begin failures++; $display("[TB] FAIL ovf_kept_count got=%0d exp=4", evt_count); end
        checks++; if (evt_data !== 8'h40) begin failures++; $display("[TB] FAIL ovf_kept_head got=%h exp=40", evt_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expOrder [4];
        expOrder = '{8'h41, 8'h00, 8'h01, 8'h40};
        button_data = 32'h0001_0000;
        @(negedge clk);
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
        checks++; if (evt_count !== 3'd4) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=4", evt_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overflow got=%b exp=0", overflow); end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (evt_data !== expOrder[i]) begin failures++; $display("[TB] FAIL b2b_order[%0d] got=%h exp=%h", i, evt_data, expOrder[i]); end
            popOne();
        end
        popOne();
        checks++; if (evt_count !== 3'd0) begin failures++; $display("[TB] FAIL empty_pop_count got=%0d exp=0", evt_count); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL empty_pop_valid got=%b exp=0", evt_valid); end
    endtask

    task automatic test_reset_midscan();
        rst_n = 1'b0;
        button_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        button_data = 32'h8001_0000;
        repeat (8) @(negedge clk);
        checks++; if (evt_count !== 3'd1) begin failures++; $display("[TB] FAIL midscan_pre_count got=%0d exp=1", evt_count); end
        rst_n = 1'b0;
        #1;
        checks++; if (evt_count !== 3'd0) begin failures++; $display("[TB] FAIL midscan_rst_count got=%0d exp=0", evt_count); end
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL midscan_rst_valid got=%b exp=0", evt_valid); end
        checks++; if (evt_data !== 8'h00) begin failures++; $display("[TB] FAIL midscan_rst_data got=%h exp=00", evt_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (evt_count !== 3'd2) begin failures++; $display("[TB] FAIL midscan_after_count got=%0d exp=2", evt_count); end
        checks++; if (evt_data !== 8'h40) begin failures++; $display("[TB] FAIL midscan_after_first got=%h exp=40", evt_data); end
        popOne();
        checks++; if (evt_data !== 8'h4F) begin failures++; $display("[TB] FAIL midscan_after_second got=%h exp=4f", evt_data); end
        popOne();
    endtask

    initial begin
        test_reset();
        test_press();
        test_swap();
        test_stick();
        test_mask();
        test_enable();
        test_overflow();
        test_back_to_back();
        test_reset_midscan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
